ws2811_refresh_scheduler: RTL and testbench

Shares the WS2811 LED string between two colour writers (A: game logic, B: animation engine) and sequences frame transmission through the WS2811 array controller. Writers place per-LED colours into a shadow buffer through an arbitrated valid/ready port. The scheduler copies the shadow buffer into an active frame register, which drives the array controller's external RGB inputs. It then runs the array controller through one full frame, rate-limited to a minimum frame period.

---
 rtl/ws2811_refresh_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ws2811_refresh_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2811_refresh_scheduler.sv
// ws2811_refresh_scheduler
// Two-writer colour front end for a WS2811 string. Writers A and B post
// per-LED colour beats into a shadow buffer through a round-robin
// valid/ready port. When a frame is marked dirty, the scheduler copies the
// shadow buffer into the active frame register. It then runs the array
// controller for one frame. The frame start rate is limited by a minimum
// period, and a watchdog bounds the time spent in SEND.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a dirty frame
// LATCH | one cycle: active <= shadow, restart period and watchdog counts
// SEND  | array controller enabled, waiting for frame_done or watchdog
// GAP   | holding off until the minimum frame period has elapsed
module ws2811_refresh_scheduler #(
  parameter int LED_COUNT           = 11,
  parameter int MIN_PERIOD_CYCLES   = 500000,
  parameter int SEND_TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [3:0]             a_index,
  input  logic [23:0]            a_rgb,
  input  logic                   a_last,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [3:0]             b_index,
  input  logic [23:0]            b_rgb,
  input  logic                   b_last,
  output logic                   b_ready,
  output logic                   array_enable,
  input  logic                   array_frame_done,
  output logic [24*LED_COUNT-1:0] led_frame,
  output logic [7:0]             led_count,
  output logic                   use_external_rgb,
  output logic [15:0]            frames_sent,
  output logic                   index_err,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [31:0] PERIOD_LAST  = 32'(MIN_PERIOD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(SEND_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LED_LIMIT    = 32'(LED_COUNT);

  state_t      state;
  logic        dirty;
  logic        rr_ptr;        // 0: A wins a tie, 1: B wins a tie
  logic [31:0] period_cnt;
  logic [31:0] timeout_cnt;

  logic [23:0] shadow      [LED_COUNT];
  logic [23:0] shadow_next [LED_COUNT];
  logic [23:0] active      [LED_COUNT];

  logic        grant_a;
  logic        grant_b;
  logic        grant;
  logic [3:0]  wr_index;
  logic [23:0] wr_rgb;
  logic        wr_last;
  logic        wr_in_range;
  logic        grant_last;

  // Round-robin arbitration and selection of the granted beat
  always_comb begin
    grant_a     = a_valid && (!b_valid || !rr_ptr);
    grant_b     = b_valid && (!a_valid ||  rr_ptr);
    grant       = grant_a || grant_b;
    wr_index    = grant_b ? b_index : a_index;
    wr_rgb      = grant_b ? b_rgb   : a_rgb;
    wr_last     = grant_b ? b_last  : a_last;
    wr_in_range = (32'(wr_index) < LED_LIMIT);
    grant_last  = grant && wr_last;
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign led_count = 8'(LED_COUNT);

  // Shadow contents after this cycle's beat, so LATCH can capture a same-cycle write
  always_comb begin
    for (int i = 0; i < LED_COUNT; i++) begin
      shadow_next[i] = shadow[i];
      if (grant && (wr_index == 4'(i)))
        shadow_next[i] = wr_rgb;
    end
  end

  // Shadow buffer takes every granted in-range beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LED_COUNT; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < LED_COUNT; i++) shadow[i] <= shadow_next[i];
    end
  end

  // Active frame changes only while latching
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LED_COUNT; i++) active[i] <= '0;
    end else if (state == LATCH) begin
      for (int i = 0; i < LED_COUNT; i++) active[i] <= shadow_next[i];
    end
  end

  // Flatten the active frame onto the external RGB bus
  always_comb begin
    led_frame = '0;
    for (int i = 0; i < LED_COUNT; i++)
      led_frame[24*i +: 24] = active[i];
  end

  // Frame sequencer, arbitration pointer, dirty flag and status registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      dirty            <= 1'b0;
      rr_ptr           <= 1'b0;
      period_cnt       <= '0;
      timeout_cnt      <= '0;
      array_enable     <= 1'b0;
      use_external_rgb <= 1'b0;
      frames_sent      <= '0;
      index_err        <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      if (grant)
        rr_ptr <= grant_a;
      if (grant && !wr_in_range)
        index_err <= 1'b1;
      if (grant_last)
        dirty <= 1'b1;

      case (state)
        IDLE: begin
          if (dirty || grant_last)
            state <= LATCH;
        end
        LATCH: begin
          // A last beat arriving while latching keeps the frame dirty
          dirty            <= grant_last;
          use_external_rgb <= 1'b1;
          period_cnt       <= '0;
          timeout_cnt      <= '0;
          array_enable     <= 1'b1;
          state            <= SEND;
        end
        SEND: begin
          period_cnt  <= period_cnt + 32'd1;
          timeout_cnt <= timeout_cnt + 32'd1;
          if (array_frame_done) begin
            array_enable <= 1'b0;
            frames_sent  <= frames_sent + 16'd1;
            state        <= GAP;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            array_enable <= 1'b0;
            timeout_err  <= 1'b1;
            state        <= GAP;
          end
        end
        GAP: begin
          period_cnt <= period_cnt + 32'd1;
          if (period_cnt >= PERIOD_LAST)
            state <= IDLE;
        end
        default: begin
          array_enable <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_refresh_scheduler.sv
// Testbench for ws2811_refresh_scheduler: arbitration vector table plus
// directed multi-cycle sequences for latching, frame period, isolation,
// index errors, watchdog and asynchronous reset.
module tb_ws2811_refresh_scheduler;

  localparam int N  = 11;
  localparam int FW = 24 * N;

  logic          clock;
  logic          reset;
  logic          a_valid, b_valid;
  logic [3:0]    a_index, b_index;
  logic [23:0]   a_rgb, b_rgb;
  logic          a_last, b_last;
  logic          a_ready, b_ready;
  logic          array_enable;
  logic          array_frame_done;
  logic [FW-1:0] led_frame;
  logic [7:0]    led_count;
  logic          use_external_rgb;
  logic [15:0]   frames_sent;
  logic          index_err;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  logic [23:0]   exp_shadow [N];
  logic [FW-1:0] exp_frame;

  typedef struct {
    logic        av; logic [3:0] ai; logic [23:0] ar; logic al;
    logic        bv; logic [3:0] bi; logic [23:0] br; logic bl;
    logic        ea; logic eb;
  } vec_t;
  vec_t vecs [11];

  ws2811_refresh_scheduler #(
    .LED_COUNT(N), .MIN_PERIOD_CYCLES(20), .SEND_TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_index(a_index), .a_rgb(a_rgb), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_index(b_index), .b_rgb(b_rgb), .b_last(b_last), .b_ready(b_ready),
    .array_enable(array_enable), .array_frame_done(array_frame_done),
    .led_frame(led_frame), .led_count(led_count), .use_external_rgb(use_external_rgb),
    .frames_sent(frames_sent), .index_err(index_err), .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000 ns");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] frame_of();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[24*i +: 24] = exp_shadow[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_shadow[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    clear_model();
    tick();
  endtask

  // One A-only beat; returns in the cycle after the grant edge
  task automatic a_beat(input logic [3:0] idx, input logic [23:0] rgb, input logic last);
    a_valid = 1'b1; a_index = idx; a_rgb = rgb; a_last = last;
    #1;
    chk("a_beat_ready", a_ready, 1'b1);
    if (32'(idx) < N) exp_shadow[idx] = rgb;
    @(posedge clock);
    #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic send_done();
    array_frame_done = 1'b1;
    tick();
    array_frame_done = 1'b0;
  endtask

  initial begin
    int  k;
    int  n;
    logic rose;
    logic iso_ok;

    reset = 1'b0;
    a_valid = 0; a_index = 0; a_rgb = 0; a_last = 0;
    b_valid = 0; b_index = 0; b_rgb = 0; b_last = 0;
    array_frame_done = 0;
    clear_model();

    vecs[0]  = '{1'b1, 4'd0, 24'hA00000, 1'b0, 1'b1, 4'd0, 24'h0B0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 24'hA00001, 1'b0, 1'b1, 4'd1, 24'h0B0001, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 4'd2, 24'hA00002, 1'b0, 1'b1, 4'd2, 24'h0B0002, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'd3, 24'hA00003, 1'b0, 1'b1, 4'd3, 24'h0B0003, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'd4, 24'hA00004, 1'b0, 1'b1, 4'd4, 24'h0B0004, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd5, 24'hA00005, 1'b0, 1'b1, 4'd5, 24'h0B0005, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'd6, 24'hA00006, 1'b0, 1'b0, 4'd6, 24'h0B0006, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd7, 24'hA00007, 1'b0, 1'b1, 4'd7, 24'h0B0007, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'd9, 24'hEEEEEE, 1'b0, 1'b0, 4'd9, 24'hEEEEEE, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd8, 24'hA00008, 1'b0, 1'b1, 4'd8, 24'h0B0008, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'd9, 24'hA00009, 1'b1, 1'b1, 4'd9, 24'h0B0009, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_enable", array_enable, 1'b0);
    chk("rst_frame", led_frame, '0);
    chk("rst_led_count", led_count, 8'd11);
    chk("rst_ext", use_external_rgb, 1'b0);
    chk("rst_frames", frames_sent, 16'd0);
    chk("rst_index_err", index_err, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_ready", {a_ready, b_ready}, 2'b00);
    reset = 1'b1;
    tick();

    // First frame latency and contents
    a_beat(4'd0, 24'hFF0000, 1'b0);
    a_beat(4'd10, 24'h0000FF, 1'b1);
    chk("t1_latch_enable", array_enable, 1'b0);
    chk("t1_latch_ext", use_external_rgb, 1'b0);
    tick();
    chk("t1_enable", array_enable, 1'b1);
    chk("t1_led0", led_frame[23:0], 24'hFF0000);
    chk("t1_led10", led_frame[263:240], 24'h0000FF);
    chk("t1_ext", use_external_rgb, 1'b1);
    chk("t1_frame", led_frame, frame_of());
    repeat (3) tick();
    send_done();
    chk("t1_frames", frames_sent, 16'd1);
    chk("t1_enable_off", array_enable, 1'b0);

    // Arbitration table from a fresh rr_ptr
    do_reset();
    chk("t2_rst_frame", led_frame, '0);
    for (int r = 0; r < 11; r++) begin
      a_valid = vecs[r].av; a_index = vecs[r].ai; a_rgb = vecs[r].ar; a_last = vecs[r].al;
      b_valid = vecs[r].bv; b_index = vecs[r].bi; b_rgb = vecs[r].br; b_last = vecs[r].bl;
      #1;
      chk($sformatf("t2_row%0d_a_ready", r), a_ready, vecs[r].ea);
      chk($sformatf("t2_row%0d_b_ready", r), b_ready, vecs[r].eb);
      if (vecs[r].ea) exp_shadow[vecs[r].ai] = vecs[r].ar;
      if (vecs[r].eb) exp_shadow[vecs[r].bi] = vecs[r].br;
      tick();
    end
    a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
    tick();
    chk("t2_ungranted_last_no_frame", array_enable, 1'b0);
    a_beat(4'd10, 24'hC0FFEE, 1'b1);
    tick();
    chk("t2_enable", array_enable, 1'b1);
    exp_frame = frame_of();
    chk("t2_frame", led_frame, exp_frame);

    // Frame period with a dirty beat pending during SEND
    a_beat(4'd3, 24'h123456, 1'b1);
    k = 1;
    repeat (3) begin tick(); k++; end
    send_done();
    k++;
    chk("t3_enable_off", array_enable, 1'b0);
    chk("t3_frames1", frames_sent, 16'd1);
    iso_ok = 1'b1; rose = 1'b0;
    for (int j = 0; j < 60 && !rose; j++) begin
      tick(); k++;
      if (array_enable) rose = 1'b1;
      else if (led_frame !== exp_frame) iso_ok = 1'b0;
    end
    chk("t3_second_frame", rose, 1'b1);
    chk("t3_isolation", iso_ok, 1'b1);
    chk("t3_period_min", (k >= 20), 1'b1);
    chk("t3_period_max", (k <= 22), 1'b1);
    exp_frame = frame_of();
    chk("t3_frame", led_frame, exp_frame);
    repeat (2) tick();
    send_done();
    chk("t3_frames2", frames_sent, 16'd2);

    // Writes without last, stray done outside SEND
    a_beat(4'd4, 24'h444444, 1'b0);
    send_done();
    chk("t4_stray_done", frames_sent, 16'd2);
    rose = 1'b0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (array_enable) rose = 1'b1;
    end
    chk("t4_no_frame", rose, 1'b0);
    chk("t4_frame_held", led_frame, exp_frame);

    // Last beat granted during LATCH: in this frame and keeps dirty
    a_beat(4'd5, 24'h555555, 1'b1);
    a_beat(4'd6, 24'h666666, 1'b1);
    chk("t4b_enable", array_enable, 1'b1);
    exp_frame = frame_of();
    chk("t4b_frame", led_frame, exp_frame);
    repeat (2) tick();
    send_done();
    chk("t4b_frames3", frames_sent, 16'd3);
    rose = 1'b0;
    for (int j = 0; j < 60 && !rose; j++) begin
      tick();
      if (array_enable) rose = 1'b1;
    end
    chk("t4b_resend", rose, 1'b1);
    chk("t4b_resend_frame", led_frame, exp_frame);
    send_done();
    chk("t4b_frames4", frames_sent, 16'd4);
    repeat (25) tick();

    // Out-of-range index
    chk("t5_err_before", index_err, 1'b0);
    a_beat(4'd12, 24'hDEADBE, 1'b0);
    chk("t5_err_set", index_err, 1'b1);
    repeat (3) tick();
    chk("t5_err_sticky", index_err, 1'b1);
    a_beat(4'd0, 24'h00FF00, 1'b1);
    tick();
    chk("t5_enable", array_enable, 1'b1);
    exp_frame = frame_of();
    chk("t5_frame", led_frame, exp_frame);
    send_done();
    chk("t5_frames5", frames_sent, 16'd5);
    repeat (25) tick();

    // SEND watchdog
    a_beat(4'd1, 24'h010101, 1'b1);
    tick();
    n = 0;
    for (int j = 0; j < 100 && array_enable; j++) begin
      n++;
      tick();
    end
    chk("t6_send_len", n, 50);
    chk("t6_timeout_err", timeout_err, 1'b1);
    chk("t6_frames", frames_sent, 16'd5);
    repeat (5) tick();

    // Asynchronous reset in SEND
    a_beat(4'd2, 24'h020202, 1'b1);
    tick();
    chk("t6_send_again", array_enable, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_enable", array_enable, 1'b0);
    chk("t6_async_frame", led_frame, '0);
    chk("t6_async_frames", frames_sent, 16'd0);
    chk("t6_async_errs", {index_err, timeout_err, use_external_rgb}, 3'b000);
    @(posedge clock);
    #1;
    reset = 1'b1;
    clear_model();
    tick();
    a_beat(4'd0, 24'h010203, 1'b1);
    tick();
    chk("t6_post_rst_enable", array_enable, 1'b1);
    exp_frame = frame_of();
    chk("t6_shadow_cleared", led_frame, exp_frame);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
